// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, drives every datapath enable and select, and counts retired instructions.
module multicycle_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       AluOp,
  output logic             IllegalOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] ADDIEXEC = 4'd10;
  localparam logic [3:0] ADDIWB   = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0]       state;
  logic [3:0]       nextState;
  logic [3:0]       decState;
  logic             retire;
  logic [CNT_W-1:0] instrCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      instrCnt <= '0;
    end else begin
      state <= nextState;
      if (retire) instrCnt <= instrCnt + CNT_W'(1);
    end
  end

  always_comb begin
    nextState = FETCH;
    retire    = 1'b0;
    case (state)
      FETCH:    nextState = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECUTE;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          OP_ADDI:      nextState = ADDIEXEC;
          default:      nextState = FETCH;
        endcase
      end
      // Op comes from the IR, which is stable for the whole instruction.
      MEMADR:   nextState = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    nextState = MemReady ? MEMWB : MEMRD;
      MEMWB:    retire = 1'b1;
      MEMWR: begin
        nextState = MemReady ? FETCH : MEMWR;
        retire    = MemReady;
      end
      EXECUTE:  nextState = ALUWB;
      ALUWB:    retire = 1'b1;
      BRANCH:   retire = 1'b1;
      JUMP:     retire = 1'b1;
      ADDIEXEC: nextState = ADDIWB;
      ADDIWB:   retire = 1'b1;
      default:  nextState = FETCH;
    endcase
  end

  // While reset is held the datapath sees FETCH controls regardless of the state register.
  assign decState = reset ? FETCH : state;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    AluOp       = 2'b00;
    IllegalOp   = 1'b0;
    case (decState)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: IllegalOp = 1'b0;
          default:                                   IllegalOp = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:   RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign State      = state;
  assign InstrCount = instrCnt;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: state traces, per-state controls,
// memory waits, illegal opcode, reset abort and a 4-bit counter wrap.
module tb_multicycle_main_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Op;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  ALUSrcB, PCSource, AluOp;
  logic [3:0]  State;
  logic [15:0] InstrCount;

  logic        sPCWrite, sPCWriteCond, sIorD, sMemRead, sMemWrite, sMemtoReg;
  logic        sIRWrite, sRegDst, sRegWrite, sALUSrcA, sIllegalOp;
  logic [1:0]  sALUSrcB, sPCSource, sAluOp;
  logic [3:0]  sState;
  logic [3:0]  sInstrCount;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  multicycle_main_control #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .AluOp(AluOp), .IllegalOp(IllegalOp), .State(State),
    .InstrCount(InstrCount)
  );

  multicycle_main_control #(.CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(sPCWrite), .PCWriteCond(sPCWriteCond), .IorD(sIorD),
    .MemRead(sMemRead), .MemWrite(sMemWrite), .MemtoReg(sMemtoReg),
    .IRWrite(sIRWrite), .RegDst(sRegDst), .RegWrite(sRegWrite),
    .ALUSrcA(sALUSrcA), .ALUSrcB(sALUSrcB), .PCSource(sPCSource),
    .AluOp(sAluOp), .IllegalOp(sIllegalOp), .State(sState),
    .InstrCount(sInstrCount)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and sample 1 time unit after the edge; read/write exclusivity checked every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    checkVal("rdwrExclusive", {31'b0, MemRead & MemWrite}, 0);
  endtask

  task automatic runJump();
    Op = 6'b000010;
    step(); checkVal("jDecode", State, 1);
    step(); checkVal("jState", State, 9);
    step(); checkVal("jReturn", State, 0);
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b1; Op = 6'b000000;
    step();
    checkVal("rstState", State, 0);
    checkVal("rstMemRead", MemRead, 1);
    checkVal("rstIRWrite", IRWrite, 1);
    checkVal("rstPCWrite", PCWrite, 1);
    checkVal("rstAluOp", AluOp, 0);
    checkVal("rstCount", InstrCount, 0);
    reset = 1'b0;

    // R-type
    step(); checkVal("rDecode", State, 1);
    checkVal("rDecALUSrcB", ALUSrcB, 2'b11);
    step(); checkVal("rExec", State, 6);
    checkVal("rExecAluOp", AluOp, 2'b10);
    checkVal("rExecSrcA", ALUSrcA, 1);
    step(); checkVal("rWb", State, 7);
    checkVal("rWbRegWrite", RegWrite, 1);
    checkVal("rWbRegDst", RegDst, 1);
    step(); checkVal("rReturn", State, 0);
    checkVal("rCount", InstrCount, 1);

    // lw with two wait cycles in MEMRD
    Op = 6'b100011;
    step(); checkVal("lwDecode", State, 1);
    step(); checkVal("lwMemAdr", State, 2);
    checkVal("lwAdrSrcB", ALUSrcB, 2'b10);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("lwMemRd", State, 3);
      checkVal("lwMemRdRead", MemRead, 1);
      checkVal("lwMemRdIorD", IorD, 1);
    end
    MemReady = 1'b1;
    step(); checkVal("lwMemWb", State, 4);
    checkVal("lwMemtoReg", MemtoReg, 1);
    checkVal("lwRegWrite", RegWrite, 1);
    checkVal("lwRegDst", RegDst, 0);
    step(); checkVal("lwReturn", State, 0);
    checkVal("lwCount", InstrCount, 2);

    // sw, beq, j, addi back-to-back
    Op = 6'b101011;
    step(); checkVal("swDecode", State, 1);
    step(); checkVal("swMemAdr", State, 2);
    step(); checkVal("swMemWr", State, 5);
    checkVal("swMemWrite", MemWrite, 1);
    checkVal("swMemRead", MemRead, 0);
    step(); checkVal("swReturn", State, 0);
    Op = 6'b000100;
    step(); checkVal("beqDecode", State, 1);
    step(); checkVal("beqBranch", State, 8);
    checkVal("beqAluOp", AluOp, 2'b01);
    checkVal("beqPCWriteCond", PCWriteCond, 1);
    checkVal("beqPCSource", PCSource, 2'b01);
    step(); checkVal("beqReturn", State, 0);
    Op = 6'b000010;
    step(); checkVal("jDecode0", State, 1);
    step(); checkVal("jJump", State, 9);
    checkVal("jPCSource", PCSource, 2'b10);
    checkVal("jPCWrite", PCWrite, 1);
    step(); checkVal("jReturn0", State, 0);
    Op = 6'b001000;
    step(); checkVal("addiDecode", State, 1);
    step(); checkVal("addiExec", State, 10);
    checkVal("addiSrcB", ALUSrcB, 2'b10);
    step(); checkVal("addiWb", State, 11);
    checkVal("addiRegWrite", RegWrite, 1);
    checkVal("addiRegDst", RegDst, 0);
    step(); checkVal("addiReturn", State, 0);
    checkVal("seqCount", InstrCount, 6);

    // Illegal opcode
    Op = 6'b111111;
    step(); checkVal("illDecode", State, 1);
    checkVal("illPulse", IllegalOp, 1);
    step(); checkVal("illReturn", State, 0);
    checkVal("illPulseEnd", IllegalOp, 0);
    checkVal("illCount", InstrCount, 6);

    // FETCH stall
    Op = 6'b000010;
    MemReady = 1'b0;
    #1;
    checkVal("stallIRWrite", IRWrite, 0);
    checkVal("stallPCWrite", PCWrite, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("stallState", State, 0);
      checkVal("stallIRWriteHold", IRWrite, 0);
    end
    MemReady = 1'b1;
    #1;
    checkVal("stallIRWriteRel", IRWrite, 1);
    checkVal("stallPCWriteRel", PCWrite, 1);
    step(); checkVal("stallDecode", State, 1);
    step(); checkVal("stallJump", State, 9);
    step(); checkVal("stallReturn", State, 0);
    checkVal("stallCount", InstrCount, 7);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 8; i++) runJump();
    checkVal("wrapSmallPre", sInstrCount, 15);
    checkVal("wrapBigPre", InstrCount, 15);
    runJump();
    checkVal("wrapSmall", sInstrCount, 0);
    checkVal("wrapBig", InstrCount, 16);

    // Reset abort while waiting in MEMWR
    Op = 6'b101011;
    step(); checkVal("abDecode", State, 1);
    step(); checkVal("abMemAdr", State, 2);
    MemReady = 1'b0;
    step(); checkVal("abMemWr", State, 5);
    step(); checkVal("abMemWrWait", State, 5);
    checkVal("abMemWriteWait", MemWrite, 1);
    reset = 1'b1;
    #1;
    checkVal("abMemWriteInRst", MemWrite, 0);
    step();
    checkVal("abState", State, 0);
    checkVal("abCount", InstrCount, 0);
    checkVal("abMemWrite", MemWrite, 0);
    checkVal("abSmallCount", sInstrCount, 0);
    reset = 1'b0;
    MemReady = 1'b1;
    step();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
Main control state machine for the multicycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback. It produces all datapath enables and mux selects, including the 2-bit AluOp that the ALU control decoder consumes alongside the funct field. Memory states wait on a MemReady handshake, and a retired-instruction counter is provided for debug and performance.

Parameters:
CNT_W, 16, width of the InstrCount retired-instruction counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Op  input  6  opcode field, IR[31:26]
MemReady  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write qualified by ALU Zero (beq)
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemtoReg  output  1  register write data select: 1=MDR, 0=ALUOut
IRWrite  output  1  instruction register load
RegDst  output  1  destination register select: 1=rd, 0=rt
RegWrite  output  1  register file write
ALUSrcA  output  1  ALU A select: 0=PC, 1=A register
ALUSrcB  output  2  ALU B select: 00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
PCSource  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
AluOp  output  2  to ALU control: 00=add, 01=sub, 10=use funct
IllegalOp  output  1  one-cycle pulse in DECODE when Op is unsupported
State  output  4  current state encoding, for debug
InstrCount  output  CNT_W  retired-instruction count

Behaviour:
- Moore FSM with a registered 4-bit state. Outputs decode from the state; IRWrite and PCWrite in FETCH are additionally gated by MemReady. Any output not listed for a state is 0.
- Reset: state=FETCH(0), InstrCount=0. Reset asserted mid-instruction aborts it; the next state is FETCH with no count increment. During reset the outputs reflect FETCH decode.
- Supported opcodes: lw=100011, sw=101011, R-type=000000, beq=000100, j=000010, addi=001000.
- State 0 FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSource=00, IRWrite=MemReady, PCWrite=MemReady.
  - Next state: DECODE if MemReady, else stay.
- State 1 DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, AluOp=00.
  - Next state by Op: lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, j->JUMP, addi->ADDIEXEC.
  - Any other Op: IllegalOp=1, next state FETCH, no count increment.
- State 2 MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=00. Next state: lw->MEMRD, sw->MEMWR. Op is sampled live; the IR holds it stable.
- State 3 MEMRD: MemRead=1, IorD=1. Next state: MEMWB if MemReady, else stay.
- State 4 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next state: FETCH.
- State 5 MEMWR: MemWrite=1, IorD=1. Next state: FETCH if MemReady, else stay.
- State 6 EXECUTE: ALUSrcA=1, ALUSrcB=00, AluOp=10. Next state: ALUWB.
- State 7 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next state: FETCH.
- State 8 BRANCH: ALUSrcA=1, ALUSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01. Next state: FETCH.
- State 9 JUMP: PCWrite=1, PCSource=10. Next state: FETCH.
- State 10 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, AluOp=00. Next state: ADDIWB.
- State 11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next state: FETCH.
- States 12-15 are unreachable: all outputs 0, next state FETCH.
- InstrCount increments by 1 on the edge leaving MEMWB, MEMWR (with MemReady), ALUWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W.
- Zero-wait latency in cycles, FETCH through return: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- MemWrite and MemRead are never both 1 in the same cycle.

Test Plan:
- Reset with MemReady=1, Op=000000 -> State=0 FETCH, MemRead=1, IRWrite=1, PCWrite=1, AluOp=00, InstrCount=0. Release reset -> State sequence 0,1,6,7,0. AluOp=10 in state 6, RegWrite=1/RegDst=1 in state 7, InstrCount=1.
- lw with MemReady low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemRead=IorD=1 throughout state 3, MemtoReg=1 in state 4, InstrCount=+1.
- sw, beq, j, addi back-to-back at zero wait -> State traces 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11. beq has AluOp=01, PCWriteCond=1; j has PCSource=10. InstrCount=+4.
- Op=111111 -> IllegalOp=1 for exactly one cycle in state 1, then state 0, InstrCount unchanged.
- Stall in FETCH with MemReady=0 for 3 cycles -> State=0 held, IRWrite=PCWrite=0 until MemReady=1.
- Assert reset while in MEMWR with MemReady=0 -> next cycle State=0, InstrCount=0, MemWrite=0. Also check CNT_W=4 wraps 15->0.
